// File: rtl/stage_ex_divider.sv
// Radix-2 restoring divide sequencer for DIV/DIVU beside the EX stage (IDLE/ZERO/BUSY/END).
// Define DIVIDER_SIGNED_EN to honour signed_mode; otherwise every divide is unsigned.
module stage_ex_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             annul,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             done,
    output logic             divide_by_zero,
    output logic             stall_request
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ZERO = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;
    localparam logic [1:0] S_END  = 2'd3;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_result_lo;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_upper;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quot_next;
    logic [WIDTH-1:0] w_q_final;
    logic [WIDTH-1:0] w_r_final;
    logic             w_accept;
    logic             w_accept_busy;
    logic             w_last;

    assign w_accept      = (r_state == S_IDLE) && start && !annul;
    assign w_accept_busy = w_accept && (operand_b != '0);
    assign w_last        = (r_count == LAST_COUNT);

    // r_quot starts as the dividend and fills with quotient bits as the pair shifts left.
    assign w_upper     = {r_rem, r_quot[WIDTH-1]};
    assign w_diff      = w_upper - {1'b0, r_divisor};
    assign w_fits      = ~w_diff[WIDTH];
    assign w_rem_next  = w_fits ? w_diff[WIDTH-1:0] : w_upper[WIDTH-1:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], w_fits};

`ifdef DIVIDER_SIGNED_EN
    logic w_a_neg;
    logic w_b_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_neg   = signed_mode & operand_a[WIDTH-1];
    assign w_b_neg   = signed_mode & operand_b[WIDTH-1];
    assign w_a_mag   = w_a_neg ? -operand_a : operand_a;
    assign w_b_mag   = w_b_neg ? -operand_b : operand_b;
    assign w_q_final = r_neg_q ? -w_quot_next : w_quot_next;
    assign w_r_final = r_neg_r ? -w_rem_next : w_rem_next;

    // Quotient negates on differing signs; remainder follows the dividend.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept_busy) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end
    end
`else
    logic w_unused_signed_mode;

    assign w_unused_signed_mode = signed_mode;
    assign w_a_mag   = operand_a;
    assign w_b_mag   = operand_b;
    assign w_q_final = w_quot_next;
    assign w_r_final = w_rem_next;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_divisor   <= '0;
            r_result_lo <= '0;
            r_result_hi <= '0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else if (annul) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dbz <= 1'b0;
                        if (operand_b == '0) begin
                            r_state <= S_ZERO;
                        end else begin
                            r_state   <= S_BUSY;
                            r_rem     <= '0;
                            r_quot    <= w_a_mag;
                            r_divisor <= w_b_mag;
                            r_count   <= '0;
                        end
                    end
                end
                S_ZERO: begin
                    r_state     <= S_END;
                    r_result_lo <= '0;
                    r_result_hi <= '0;
                    r_dbz       <= 1'b1;
                    r_done      <= 1'b1;
                end
                S_BUSY: begin
                    r_rem   <= w_rem_next;
                    r_quot  <= w_quot_next;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_state     <= S_END;
                        r_result_lo <= w_q_final;
                        r_result_hi <= w_r_final;
                        r_done      <= 1'b1;
                    end
                end
                S_END: begin
                    if (!start) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // annul releases the pipeline in the same cycle it is raised.
    assign stall_request  = !annul && (w_accept || (r_state == S_ZERO) || (r_state == S_BUSY));
    assign result_lo      = r_result_lo;
    assign result_hi      = r_result_hi;
    assign done           = r_done;
    assign divide_by_zero = r_dbz;
endmodule

// File: tb/tb_stage_ex_divider.sv
// Self-checking bench for stage_ex_divider: directed plan cases plus randomized divides
// checked against an arithmetic reference model (honours DIVIDER_SIGNED_EN when defined).
module tb_stage_ex_divider;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic        annul;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        done;
    logic        divide_by_zero;
    logic        stall_request;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    stage_ex_divider #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .signed_mode    (signed_mode),
        .annul          (annul),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .result_lo      (result_lo),
        .result_hi      (result_hi),
        .done           (done),
        .divide_by_zero (divide_by_zero),
        .stall_request  (stall_request)
    );

    // Reference: plain 64-bit arithmetic (truncating division, remainder follows dividend).
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic mode,
                                    output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa;
        longint sb;
        longint sq;
        longint sr;
        bit     use_signed;
        use_signed = mode;
`ifndef DIVIDER_SIGNED_EN
        use_signed = 1'b0;
`endif
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
            z = 1'b1;
        end else begin
            if (use_signed) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'(a);
                sb = longint'(b);
            end
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
            z  = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one divide from IDLE, waits (bounded) for done, then drops start for one cycle.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic mode,
                           output logic [31:0] lo, output logic [31:0] hi, output logic z,
                           output int lat, output logic done_after);
        operand_a   = a;
        operand_b   = b;
        signed_mode = mode;
        start       = 1'b1;
        lat         = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat < 100);
        lo    = result_lo;
        hi    = result_hi;
        z     = divide_by_zero;
        start = 1'b0;
        tick();
        done_after = done;
        $display("div a=%h b=%h signed=%0d -> lo=%h hi=%h dbz=%0b latency=%0d", a, b, mode, lo, hi, z, lat);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; annul = 1'b0; signed_mode = 1'b0;
        operand_a = 32'd0; operand_b = 32'd0;
        #2;
        checks++;
        if ({result_lo, result_hi, done, divide_by_zero, stall_request} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs: got lo=%h hi=%h done=%b dbz=%b stall=%b required all 0",
                     result_lo, result_hi, done, divide_by_zero, stall_request);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_unsigned_timing();
        operand_a = 32'd100; operand_b = 32'd7; signed_mode = 1'b0; start = 1'b1;
        #1;
        checks++;
        if (stall_request !== 1'b1) begin
            errors++;
            $display("FAIL stall_cycle0: got %b required 1", stall_request);
        end
        for (int c = 1; c <= 32; c++) begin
            tick();
            checks++;
            if ({stall_request, done} !== 2'b10) begin
                errors++;
                $display("FAIL busy_cycle%0d: got stall=%b done=%b required stall=1 done=0", c, stall_request, done);
            end
        end
        tick();
        checks++;
        if ({done, stall_request, divide_by_zero, result_lo, result_hi} !== {3'b100, 32'd14, 32'd2}) begin
            errors++;
            $display("FAIL unsigned_100_7: got done=%b stall=%b dbz=%b lo=%0d hi=%0d required done=1 stall=0 dbz=0 lo=14 hi=2",
                     done, stall_request, divide_by_zero, result_lo, result_hi);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: got %b required 1 while start held", done);
        end
        start = 1'b0;
        tick();
        checks++;
        if ({done, result_lo, result_hi} !== {1'b0, 32'd14, 32'd2}) begin
            errors++;
            $display("FAIL drop_start: got done=%b lo=%0d hi=%0d required done=0 lo=14 hi=2", done, result_lo, result_hi);
        end
        $display("div a=00000064 b=00000007 signed=0 -> lo=%h hi=%h (timing walk)", result_lo, result_hi);
    endtask

    task automatic test_signed();
        logic [31:0] lo, hi, exp_lo, exp_hi;
        logic        z, da;
        int          lat;
`ifdef DIVIDER_SIGNED_EN
        exp_lo = 32'hFFFF_FFFD; exp_hi = 32'hFFFF_FFFF;
`else
        exp_lo = 32'h7FFF_FFFC; exp_hi = 32'h0000_0001;
`endif
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, lo, hi, z, lat, da);
        checks++;
        if ({lo, hi, z} !== {exp_lo, exp_hi, 1'b0}) begin
            errors++;
            $display("FAIL signed_m7_2: got lo=%h hi=%h dbz=%b required lo=%h hi=%h dbz=0", lo, hi, z, exp_lo, exp_hi);
        end
`ifdef DIVIDER_SIGNED_EN
        exp_lo = 32'h8000_0000; exp_hi = 32'h0000_0000;
`else
        exp_lo = 32'h0000_0000; exp_hi = 32'h8000_0000;
`endif
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lo, hi, z, lat, da);
        checks++;
        if ({lo, hi, z, lat} !== {exp_lo, exp_hi, 1'b0, 33}) begin
            errors++;
            $display("FAIL signed_min_m1: got lo=%h hi=%h dbz=%b lat=%0d required lo=%h hi=%h dbz=0 lat=33",
                     lo, hi, z, lat, exp_lo, exp_hi);
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] lo, hi;
        logic        z, da;
        int          lat;
        run_div(32'h1234, 32'd0, 1'b0, lo, hi, z, lat, da);
        checks++;
        if ({lo, hi, z, lat, da} !== {32'd0, 32'd0, 1'b1, 2, 1'b0}) begin
            errors++;
            $display("FAIL div_zero: got lo=%h hi=%h dbz=%b lat=%0d done_after=%b required lo=0 hi=0 dbz=1 lat=2 done_after=0",
                     lo, hi, z, lat, da);
        end
        run_div(32'd9, 32'd3, 1'b0, lo, hi, z, lat, da);
        checks++;
        if ({lo, hi, z, lat} !== {32'd3, 32'd0, 1'b0, 33}) begin
            errors++;
            $display("FAIL after_zero_9_3: got lo=%0d hi=%0d dbz=%b lat=%0d required lo=3 hi=0 dbz=0 lat=33", lo, hi, z, lat);
        end
    endtask

    task automatic test_annul();
        logic [31:0] lo, hi;
        logic        z, da;
        int          lat;
        int          done_seen;
        operand_a = 32'd1000; operand_b = 32'd3; signed_mode = 1'b0; start = 1'b1;
        repeat (10) tick();
        annul = 1'b1;
        #1;
        checks++;
        if (stall_request !== 1'b0) begin
            errors++;
            $display("FAIL annul_stall: got %b required 0", stall_request);
        end
        tick();
        annul = 1'b0; start = 1'b0;
        #1;
        checks++;
        if ({stall_request, done} !== 2'b00) begin
            errors++;
            $display("FAIL annul_idle: got stall=%b done=%b required 0 0", stall_request, done);
        end
        done_seen = 0;
        repeat (40) begin
            tick();
            if (done) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL annul_no_done: got %0d done cycles required 0", done_seen);
        end
        start = 1'b1; annul = 1'b1;
        #1;
        checks++;
        if (stall_request !== 1'b0) begin
            errors++;
            $display("FAIL annul_priority_stall: got %b required 0", stall_request);
        end
        tick();
        tick();
        start = 1'b0; annul = 1'b0;
        #1;
        checks++;
        if ({stall_request, done} !== 2'b00) begin
            errors++;
            $display("FAIL annul_priority_state: got stall=%b done=%b required 0 0", stall_request, done);
        end
        tick();
        run_div(32'd50, 32'd5, 1'b0, lo, hi, z, lat, da);
        checks++;
        if ({lo, hi, lat} !== {32'd10, 32'd0, 33}) begin
            errors++;
            $display("FAIL after_annul_50_5: got lo=%0d hi=%0d lat=%0d required lo=10 hi=0 lat=33", lo, hi, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] lo, hi;
        logic        z, da;
        int          lat;
        operand_a = 32'd12345; operand_b = 32'd67; signed_mode = 1'b0; start = 1'b1;
        repeat (15) tick();
        reset = 1'b0; start = 1'b0;
        #1;
        checks++;
        if ({result_lo, result_hi, done, divide_by_zero, stall_request} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid: got lo=%h hi=%h done=%b dbz=%b stall=%b required all 0",
                     result_lo, result_hi, done, divide_by_zero, stall_request);
        end
        tick();
        reset = 1'b1;
        tick();
        run_div(32'd7, 32'd7, 1'b0, lo, hi, z, lat, da);
        checks++;
        if ({lo, hi, lat} !== {32'd1, 32'd0, 33}) begin
            errors++;
            $display("FAIL after_reset_7_7: got lo=%0d hi=%0d lat=%0d required lo=1 hi=0 lat=33", lo, hi, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, lo, hi, eq, er;
        logic        mode, z, ez, da;
        int          lat, elat;
        for (int n = 0; n < 40; n++) begin
            a    = $urandom;
            mode = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = {1'b1, 31'($urandom_range(0, 255))};
            ref_div(a, b, mode, eq, er, ez);
            elat = ez ? 2 : 33;
            run_div(a, b, mode, lo, hi, z, lat, da);
            checks++;
            if ({lo, hi, z, lat, da} !== {eq, er, ez, elat, 1'b0}) begin
                errors++;
                $display("FAIL random_%0d: a=%h b=%h s=%0d got lo=%h hi=%h dbz=%b lat=%0d done_after=%b required lo=%h hi=%h dbz=%b lat=%0d done_after=0",
                         n, a, b, mode, lo, hi, z, lat, da, eq, er, ez, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_timing();
        test_signed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
